// File: rtl/spi_frame_counter.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_counter
// Purpose  : Sequences one SPI SRAM frame (command, address, data) on sck and
//            provides bit position, phase-end strobes and burst word count.
// Revision : 1.0
// ============================================================================
module spi_frame_counter #(
   parameter int CNT_W     = 5,
   parameter int CMD_BITS  = 8,
   parameter int ADDR_BITS = 16,
   parameter int DATA_BITS = 8,
   parameter int WORD_W    = 8,
   parameter int BURST     = 0
) (
   input  logic              sck,
   input  logic              rst_n,
   input  logic              cs_n,
   input  logic              en,
   output logic [2:0]        phase,
   output logic [CNT_W-1:0]  bit_cnt,
   output logic              phase_end,
   output logic              frame_done,
   output logic [WORD_W-1:0] word_cnt,
   output logic              overrun
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_ADDR = 3'd2,
      S_DATA = 3'd3,
      S_DONE = 3'd4
   } phase_t;

   localparam logic [CNT_W-1:0]  c_cmd_len  = CNT_W'(CMD_BITS);
   localparam logic [CNT_W-1:0]  c_addr_len = CNT_W'(ADDR_BITS);
   localparam logic [CNT_W-1:0]  c_data_len = CNT_W'(DATA_BITS);
   localparam logic [CNT_W-1:0]  c_bit_one  = CNT_W'(1);
   localparam logic [WORD_W-1:0] c_word_one = WORD_W'(1);
   localparam logic              c_burst    = (BURST != 0);

   phase_t              r_phase,    w_phase_nxt;
   logic [CNT_W-1:0]    r_bit_cnt,  w_bit_cnt_nxt;
   logic [WORD_W-1:0]   r_word_cnt, w_word_cnt_nxt;
   logic                r_overrun,  w_overrun_nxt;
   logic [CNT_W-1:0]    w_len;
   logic                w_at_end;

   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         r_phase    <= S_IDLE;
         r_bit_cnt  <= '0;
         r_word_cnt <= '0;
         r_overrun  <= 1'b0;
      end else begin
         r_phase    <= w_phase_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_word_cnt <= w_word_cnt_nxt;
         r_overrun  <= w_overrun_nxt;
      end
   end

   always_comb begin
      w_len = '0;
      case (r_phase)
         S_CMD:   w_len = c_cmd_len;
         S_ADDR:  w_len = c_addr_len;
         S_DATA:  w_len = c_data_len;
         default: w_len = '0;
      endcase
   end

   // IDLE/DONE also have bit_cnt == len == 0, so the phase gates the strobe
   assign w_at_end = ((r_phase == S_CMD) || (r_phase == S_ADDR) || (r_phase == S_DATA))
                     && (r_bit_cnt == w_len);

   always_comb begin
      w_phase_nxt    = r_phase;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_word_cnt_nxt = r_word_cnt;
      w_overrun_nxt  = r_overrun;
      if (cs_n) begin
         w_phase_nxt    = S_IDLE;
         w_bit_cnt_nxt  = '0;
         w_word_cnt_nxt = '0;
         w_overrun_nxt  = 1'b0;
      end else if (en) begin
         case (r_phase)
            S_IDLE: begin
               w_phase_nxt   = S_CMD;
               w_bit_cnt_nxt = c_bit_one;
            end
            S_CMD, S_ADDR: begin
               if (w_at_end) begin
                  w_phase_nxt   = (r_phase == S_CMD) ? S_ADDR : S_DATA;
                  w_bit_cnt_nxt = c_bit_one;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + c_bit_one;
               end
            end
            S_DATA: begin
               if (!w_at_end) begin
                  w_bit_cnt_nxt = r_bit_cnt + c_bit_one;
               end else if (c_burst) begin
                  // word is counted as the next one begins
                  w_bit_cnt_nxt  = c_bit_one;
                  w_word_cnt_nxt = r_word_cnt + c_word_one;
               end else begin
                  w_phase_nxt    = S_DONE;
                  w_bit_cnt_nxt  = '0;
                  w_word_cnt_nxt = c_word_one;
                  w_overrun_nxt  = 1'b1;
               end
            end
            S_DONE: begin
               w_overrun_nxt = 1'b1;
            end
            default: begin
               w_phase_nxt   = S_IDLE;
               w_bit_cnt_nxt = '0;
            end
         endcase
      end
   end

   assign phase      = r_phase;
   assign bit_cnt    = r_bit_cnt;
   assign word_cnt   = r_word_cnt;
   assign overrun    = r_overrun;
   assign phase_end  = w_at_end;
   assign frame_done = !c_burst && (r_phase == S_DATA) && (r_bit_cnt == c_data_len);

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_counter
// Purpose  : Scoreboard bench for single-word and burst spi_frame_counter.
// Revision : 1.0
// ============================================================================
module tb_spi_frame_counter;

   localparam int C = 8;
   localparam int A = 16;
   localparam int D = 8;

   typedef struct {
      int ph;
      int bc;
      int wc;
      int pe;
      int fd;
      int ov;
   } exp1_t;

   logic sck, rst_n, cs_n, en;
   logic [2:0] ph0, ph1;
   logic [4:0] bc0, bc1;
   logic       pe0, pe1, fd0, fd1, ov0, ov1;
   logic [7:0] wc0;
   logic [1:0] wc1;

   int checks;
   int failures;
   int k0;
   int k1;
   exp1_t q0[$];
   exp1_t q1[$];
   event chk_ev;

   spi_frame_counter dut0 (
      .sck(sck), .rst_n(rst_n), .cs_n(cs_n), .en(en),
      .phase(ph0), .bit_cnt(bc0), .phase_end(pe0), .frame_done(fd0),
      .word_cnt(wc0), .overrun(ov0)
   );

   spi_frame_counter #(.BURST(1), .WORD_W(2)) dut1 (
      .sck(sck), .rst_n(rst_n), .cs_n(cs_n), .en(en),
      .phase(ph1), .bit_cnt(bc1), .phase_end(pe1), .frame_done(fd1),
      .word_cnt(wc1), .overrun(ov1)
   );

   initial begin
      sck = 1'b0;
      forever #5 sck = ~sck;
   end

   // Outputs as a function of active edges since the frame began
   function automatic exp1_t calc(int k, bit burst, int wmod);
      exp1_t r;
      int len;
      int d;
      r.ph = 0; r.bc = 0; r.wc = 0; r.pe = 0; r.fd = 0; r.ov = 0;
      len = 0;
      if (k == 0) return r;
      if (k <= C) begin
         r.ph = 1; r.bc = k; len = C;
      end else if (k <= C + A) begin
         r.ph = 2; r.bc = k - C; len = A;
      end else if (!burst && k > C + A + D) begin
         r.ph = 4; r.wc = 1; r.ov = 1;
      end else begin
         d = k - C - A - 1;
         r.ph = 3; r.bc = d % D + 1; r.wc = (d / D) % wmod; len = D;
      end
      r.pe = (r.ph >= 1 && r.ph <= 3 && r.bc == len) ? 1 : 0;
      r.fd = (!burst && r.ph == 3 && r.bc == D) ? 1 : 0;
      return r;
   endfunction

   task automatic push_exp();
      q0.push_back(calc(k0, 1'b0, 256));
      q1.push_back(calc(k1, 1'b1, 4));
   endtask

   task automatic step(input bit r, input bit cs, input bit e);
      @(negedge sck);
      rst_n = r;
      cs_n  = cs;
      en    = e;
      if (!r || cs) begin
         k0 = 0;
         k1 = 0;
      end else if (e) begin
         if (k0 <= C + A + D) k0++;
         k1++;
      end
      push_exp();
   endtask

   task automatic async_reset();
      @(posedge sck);
      #3;
      rst_n = 1'b0;
      k0 = 0;
      k1 = 0;
      push_exp();
      -> chk_ev;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      exp1_t e;
      forever begin
         @(posedge sck or chk_ev);
         #1;
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("phase",      int'(ph0), e.ph);
            check("bit_cnt",    int'(bc0), e.bc);
            check("word_cnt",   int'(wc0), e.wc);
            check("phase_end",  int'(pe0), e.pe);
            check("frame_done", int'(fd0), e.fd);
            check("overrun",    int'(ov0), e.ov);
         end
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("b_phase",      int'(ph1), e.ph);
            check("b_bit_cnt",    int'(bc1), e.bc);
            check("b_word_cnt",   int'(wc1), e.wc);
            check("b_phase_end",  int'(pe1), e.pe);
            check("b_frame_done", int'(fd1), e.fd);
            check("b_overrun",    int'(ov1), e.ov);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0; failures = 0; k0 = 0; k1 = 0;
      rst_n = 1'b0; cs_n = 1'b1; en = 1'b0;

      // reset then deselected idle
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);

      // single frame plus overrun bit and a few extra DONE edges
      for (int i = 0; i < 36; i++) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);

      // stall after ADDR bit 5
      for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);

      // abort after edge 12, then fresh frame
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);

      // long burst: word_cnt wraps on the 2-bit counter
      for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0);

      // asynchronous reset at DATA bit 4
      for (int i = 0; i < 28; i++) step(1'b1, 1'b0, 1'b1);
      async_reset();
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            async_reset();
            step(1'b1, 1'b0, 1'b1);
         end else begin
            step(1'b1, ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75));
         end
      end

      @(posedge sck);
      #2;
      check("drain", q0.size() + q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_frame_counter.md
Name: spi_frame_counter

Overview:
- Parametrised successor to the 5-bit SPI bit counter.
- Sequences one SPI SRAM transaction on the serial clock through three phases: command, address, then data.
- Outputs the bit position within the current phase, phase-end strobes, a data-word count for burst transfers, and an overrun flag.
- Sits between the SPI pin interface and the SRAM command/address/data shift registers, which use its outputs as load/capture enables.

Parameters:
- CNT_W, 5: width of the bit counter. Must satisfy 2^CNT_W-1 >= max(CMD_BITS, ADDR_BITS, DATA_BITS).
- CMD_BITS, 8: command phase length in bits, >= 1.
- ADDR_BITS, 16: address phase length in bits, >= 1.
- DATA_BITS, 8: data word length in bits, >= 1.
- WORD_W, 8: width of the burst word counter.
- BURST, 0: 1 = data phase repeats while selected; 0 = single data word per frame.

Ports:
- sck  input  1  serial clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs_n  input  1  active-low chip select, sampled on sck rise.
- en  input  1  bit-valid/stall qualifier; a bit is consumed only when cs_n=0 and en=1.
- phase  output  3  0=IDLE, 1=CMD, 2=ADDR, 3=DATA, 4=DONE.
- bit_cnt  output  CNT_W  bits consumed so far in the current phase (1..len); 0 in IDLE/DONE.
- phase_end  output  1  high while bit_cnt equals the current phase length (CMD/ADDR/DATA only).
- frame_done  output  1  high while phase=DATA, bit_cnt=DATA_BITS and BURST=0.
- word_cnt  output  WORD_W  completed data words in this frame.
- overrun  output  1  sticky: a bit arrived in DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): phase=IDLE, bit_cnt=0, word_cnt=0, overrun=0; phase_end=0 and frame_done=0 as a consequence.
- All outputs are registers or decodes of registers; there is no combinational path from inputs to outputs.
- "Active edge" means a sck rise with cs_n=0 and en=1.
- cs_n=1 at any sck rise: phase<=IDLE, bit_cnt<=0, word_cnt<=0, overrun<=0. This aborts a frame mid-phase and takes priority over everything except reset.
- cs_n=0, en=0: all state holds (stall); strobes keep their current value.
- IDLE, active edge: phase<=CMD, bit_cnt<=1.
- CMD/ADDR/DATA, active edge, bit_cnt < len: bit_cnt<=bit_cnt+1.
- CMD, active edge, bit_cnt=CMD_BITS: phase<=ADDR, bit_cnt<=1. The first address bit is consumed on this edge.
- ADDR, active edge, bit_cnt=ADDR_BITS: phase<=DATA, bit_cnt<=1.
- DATA, bit_cnt=DATA_BITS, BURST=1, active edge: stay in DATA, bit_cnt<=1, word_cnt<=word_cnt+1 (wraps modulo 2^WORD_W).
- DATA, bit_cnt=DATA_BITS, BURST=0, active edge: phase<=DONE, bit_cnt<=0, word_cnt<=1, overrun<=1. The extra bit is the overrun.
- Word counting on the final word: word_cnt increments on the edge that begins the next word. In burst mode the last word is therefore counted only when another word starts. The master recovers the final total from the burst-word count + frame state at cs_n rise.
- DONE, active edge: hold DONE; overrun stays 1.
- In BURST=0, frame_done is high from the last data bit until the next active edge or cs_n rise.
- Strobe rules:
  - phase_end is level-based: high for every cycle (including stalls) in which bit_cnt equals the length of the current phase.
  - Exactly one active edge per phase sees phase_end=1 before the phase advances.
- Reset asserted mid-frame returns to IDLE immediately. After reset release, the first active edge starts a new CMD phase.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 sck, then cs_n=1 for 5 sck -> phase=0, bit_cnt=0, word_cnt=0, phase_end=0, overrun=0 throughout.
- Single frame, defaults, en=1: 32 active edges -> phase_end at edge 8 (CMD), edge 24 (ADDR), edge 32 (DATA). frame_done=1 after edge 32, word_cnt=0. Edge 33 -> phase=4, overrun=1, word_cnt=1.
- Stall: drop en for 4 cycles after bit 5 of ADDR -> bit_cnt holds 5, phase=2; resumes at 6 when en returns. Total frame still 32 active edges.
- Abort: raise cs_n after edge 12 -> next sck: phase=0, bit_cnt=0. Drop cs_n again -> a fresh frame starts at CMD bit 1.
- Burst (BURST=1, WORD_W=2): 24+8*5 active edges -> word_cnt sequence 1,2,3,0 (wrap). phase stays 3; overrun=0; frame_done never asserted.
- Async reset mid-DATA (bit_cnt=4), asserted between sck edges -> outputs clear immediately without an sck edge.
